// File: rtl/mem_access_if.sv
// Bus/handshake bundle between the LC-3 control path and the MAR/MDR memory stage.
// With MEM_MMIO_EN defined, also carries the switch input (SW) and the output register (IO_OUT).
interface mem_access_if #(parameter int ADDR_W = 16);
  logic [15:0]       BUS;
  logic              LD_MAR;
  logic              LD_MDR;
  logic              MIO_EN;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic              MEM_READY;
  logic              BUSY;
  logic [15:0]       MAR_Out;
  logic [15:0]       MDR_Out;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [15:0]       MEM_DOUT;
  logic [15:0]       MEM_DIN;
  logic              MEM_CE_N;
  logic              MEM_OE_N;
  logic              MEM_WE_N;
`ifdef MEM_MMIO_EN
  logic [9:0]        SW;
  logic [15:0]       IO_OUT;
`endif

  modport master (
    output BUS, LD_MAR, LD_MDR, MIO_EN, MEM_REQ, MEM_WE, MEM_DIN,
`ifdef MEM_MMIO_EN
    output SW,
    input  IO_OUT,
`endif
    input  MEM_READY, BUSY, MAR_Out, MDR_Out, MEM_ADDR, MEM_DOUT,
    input  MEM_CE_N, MEM_OE_N, MEM_WE_N
  );

  modport slave (
    input  BUS, LD_MAR, LD_MDR, MIO_EN, MEM_REQ, MEM_WE, MEM_DIN,
`ifdef MEM_MMIO_EN
    input  SW,
    output IO_OUT,
`endif
    output MEM_READY, BUSY, MAR_Out, MDR_Out, MEM_ADDR, MEM_DOUT,
    output MEM_CE_N, MEM_OE_N, MEM_WE_N
  );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3 MAR/MDR memory stage: one SRAM read or write per request with WAIT_CYCLES wait states.
// Optional MEM_MMIO_EN maps MAR==16'hFFFF to the SW input (reads) and IO_OUT register (writes).
//
// state  | meaning
// IDLE   | accepts LD_MAR/LD_MDR/MEM_REQ
// ACCESS | SRAM strobes active, counting down wait states
// DONE   | one-cycle MEM_READY, strobes released
module mem_access_unit #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16
) (
  input logic          Clk,
  input logic          Reset,
  mem_access_if.slave  mif
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        we_r;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        is_io;
  logic        in_access;

`ifdef MEM_MMIO_EN
  logic [15:0] io_out;
  assign is_io       = (mar == 16'hFFFF);
  assign mif.IO_OUT  = io_out;
`else
  assign is_io = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      count <= 4'd0;
      we_r  <= 1'b0;
      mar   <= 16'h0000;
      mdr   <= 16'h0000;
`ifdef MEM_MMIO_EN
      io_out <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mif.LD_MAR) mar <= mif.BUS;
          if (mif.LD_MDR && !mif.MIO_EN) mdr <= mif.BUS;
          if (mif.MEM_REQ) begin
            state <= ACCESS;
            we_r  <= mif.MEM_WE;
            count <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state <= DONE;
`ifdef MEM_MMIO_EN
            if (!we_r) mdr <= is_io ? {6'b0, mif.SW} : mif.MEM_DIN;
            if (we_r && is_io) io_out <= mdr;
`else
            if (!we_r) mdr <= mif.MEM_DIN;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the async-reset state so a reset releases them immediately.
  assign in_access     = (state == ACCESS) && !is_io;
  assign mif.MEM_CE_N  = !in_access;
  assign mif.MEM_OE_N  = !(in_access && !we_r);
  assign mif.MEM_WE_N  = !(in_access && we_r);
  assign mif.MEM_READY = (state == DONE);
  assign mif.BUSY      = (state != IDLE);
  assign mif.MAR_Out   = mar;
  assign mif.MDR_Out   = mdr;
  assign mif.MEM_ADDR  = mar[ADDR_W-1:0];
  assign mif.MEM_DOUT  = mdr;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a cycle table on a WAIT_CYCLES=2 instance plus hand
// sequences on a WAIT_CYCLES=0 instance (and the MMIO path when MEM_MMIO_EN is defined).
module tb_mem_access_unit;
  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  mem_access_if #(.ADDR_W(16)) if2 ();
  mem_access_if #(.ADDR_W(16)) if0 ();

  mem_access_unit #(.WAIT_CYCLES(2), .ADDR_W(16)) u_w2 (.Clk(Clk), .Reset(Reset), .mif(if2.slave));
  mem_access_unit #(.WAIT_CYCLES(0), .ADDR_W(16)) u_w0 (.Clk(Clk), .Reset(Reset), .mif(if0.slave));

  typedef struct {
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio, req, we;
    logic [15:0] din;
    logic        ce_n, oe_n, we_n, ready, busy;
    logic [15:0] mar, mdr;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive2(input logic [15:0] bus, input logic ld_mar, input logic ld_mdr,
                        input logic mio, input logic req, input logic we, input logic [15:0] din);
    if2.BUS = bus; if2.LD_MAR = ld_mar; if2.LD_MDR = ld_mdr;
    if2.MIO_EN = mio; if2.MEM_REQ = req; if2.MEM_WE = we; if2.MEM_DIN = din;
  endtask

  task automatic drive0(input logic [15:0] bus, input logic ld_mar, input logic ld_mdr,
                        input logic mio, input logic req, input logic we);
    if0.BUS = bus; if0.LD_MAR = ld_mar; if0.LD_MDR = ld_mdr;
    if0.MIO_EN = mio; if0.MEM_REQ = req; if0.MEM_WE = we; if0.MEM_DIN = 16'h0000;
  endtask

  initial begin
    int rdy_at [3];
    int n_rdy;

    //         bus      mar mdr mio req we din       ce oe we rdy bsy mar      mdr
    vecs[0]  = '{16'h3000, 1, 0, 1, 1, 0, 16'hBEEF, 0, 0, 1, 0, 1, 16'h3000, 16'h0000};
    vecs[1]  = '{16'h0000, 0, 0, 1, 0, 0, 16'hBEEF, 0, 0, 1, 0, 1, 16'h3000, 16'h0000};
    vecs[2]  = '{16'h0000, 0, 0, 1, 0, 0, 16'hBEEF, 0, 0, 1, 0, 1, 16'h3000, 16'h0000};
    vecs[3]  = '{16'h0000, 0, 0, 1, 0, 0, 16'hBEEF, 1, 1, 1, 1, 1, 16'h3000, 16'hBEEF};
    vecs[4]  = '{16'h0000, 0, 0, 1, 0, 0, 16'hBEEF, 1, 1, 1, 0, 0, 16'h3000, 16'hBEEF};
    vecs[5]  = '{16'h5555, 1, 1, 0, 1, 1, 16'h0000, 0, 1, 0, 0, 1, 16'h5555, 16'h5555};
    vecs[6]  = '{16'hFFFF, 1, 1, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 1, 16'h5555, 16'h5555};
    vecs[7]  = '{16'hFFFF, 1, 1, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 1, 16'h5555, 16'h5555};
    vecs[8]  = '{16'hFFFF, 1, 1, 0, 1, 0, 16'h0000, 1, 1, 1, 1, 1, 16'h5555, 16'h5555};
    vecs[9]  = '{16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h5555, 16'h5555};
    vecs[10] = '{16'h1111, 0, 1, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h5555, 16'h5555};
    vecs[11] = '{16'h2222, 0, 1, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h5555, 16'h2222};

    drive2(16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    drive0(16'h0000, 0, 0, 0, 0, 0);
`ifdef MEM_MMIO_EN
    if2.SW = 10'h000;
    if0.SW = 10'h000;
`endif
    Reset = 1'b1;
    tick(); tick();
    chk("rst_ce_n", 16'(if2.MEM_CE_N), 16'h1);
    chk("rst_oe_n", 16'(if2.MEM_OE_N), 16'h1);
    chk("rst_we_n", 16'(if2.MEM_WE_N), 16'h1);
    chk("rst_ready", 16'(if2.MEM_READY), 16'h0);
    chk("rst_busy", 16'(if2.BUSY), 16'h0);
    chk("rst_mar", if2.MAR_Out, 16'h0000);
    chk("rst_mdr", if2.MDR_Out, 16'h0000);
`ifdef MEM_MMIO_EN
    chk("rst_io_out", if2.IO_OUT, 16'h0000);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    // W=2 cycle table: read 3000, ignored inputs while busy, LD_MDR vs MIO_EN
    for (int i = 0; i < 12; i++) begin
      drive2(vecs[i].bus, vecs[i].ld_mar, vecs[i].ld_mdr, vecs[i].mio,
             vecs[i].req, vecs[i].we, vecs[i].din);
      tick();
      chk($sformatf("v%0d_ce_n", i),  16'(if2.MEM_CE_N),  16'(vecs[i].ce_n));
      chk($sformatf("v%0d_oe_n", i),  16'(if2.MEM_OE_N),  16'(vecs[i].oe_n));
      chk($sformatf("v%0d_we_n", i),  16'(if2.MEM_WE_N),  16'(vecs[i].we_n));
      chk($sformatf("v%0d_ready", i), 16'(if2.MEM_READY), 16'(vecs[i].ready));
      chk($sformatf("v%0d_busy", i),  16'(if2.BUSY),      16'(vecs[i].busy));
      chk($sformatf("v%0d_mar", i),   if2.MAR_Out,        vecs[i].mar);
      chk($sformatf("v%0d_mdr", i),   if2.MDR_Out,        vecs[i].mdr);
      chk($sformatf("v%0d_addr", i),  if2.MEM_ADDR,       vecs[i].mar);
      chk($sformatf("v%0d_dout", i),  if2.MEM_DOUT,       vecs[i].mdr);
    end
    drive2(16'h0000, 0, 0, 0, 0, 0, 16'h0000);

    // W=0 write with MDR preloaded: WE_N low one cycle, READY in cycle 2
    drive0(16'h1234, 0, 1, 0, 0, 0);
    tick();
    drive0(16'h0040, 1, 0, 0, 1, 1);
    tick();
    chk("w0_we_n_low", 16'(if0.MEM_WE_N), 16'h0);
    chk("w0_ce_n_low", 16'(if0.MEM_CE_N), 16'h0);
    chk("w0_oe_n_high", 16'(if0.MEM_OE_N), 16'h1);
    chk("w0_addr", if0.MEM_ADDR, 16'h0040);
    chk("w0_dout", if0.MEM_DOUT, 16'h1234);
    chk("w0_ready_c1", 16'(if0.MEM_READY), 16'h0);
    drive0(16'h0000, 0, 0, 0, 0, 0);
    tick();
    chk("w0_ready_c2", 16'(if0.MEM_READY), 16'h1);
    chk("w0_we_n_done", 16'(if0.MEM_WE_N), 16'h1);
    tick();
    chk("w0_busy_idle", 16'(if0.BUSY), 16'h0);
    chk("w0_ready_off", 16'(if0.MEM_READY), 16'h0);

    // W=0 LD_MAR+LD_MDR+MEM_REQ in one cycle: access uses the freshly loaded values
    drive0(16'h0040, 1, 1, 0, 1, 1);
    tick();
    chk("w0s_addr", if0.MEM_ADDR, 16'h0040);
    chk("w0s_dout", if0.MEM_DOUT, 16'h0040);
    chk("w0s_we_n", 16'(if0.MEM_WE_N), 16'h0);
    drive0(16'h0000, 0, 0, 0, 0, 0);
    tick(); tick();

    // W=2 MEM_REQ held: READY every 5 cycles
    drive2(16'h0000, 0, 0, 1, 1, 0, 16'hCAFE);
    n_rdy = 0;
    for (int k = 0; k < 30 && n_rdy < 3; k++) begin
      tick();
      if (if2.MEM_READY) begin
        rdy_at[n_rdy] = k;
        n_rdy++;
      end
    end
    chk("b2b_pulses", 16'(n_rdy), 16'd3);
    if (n_rdy == 3) begin
      chk("b2b_gap1", 16'(rdy_at[1] - rdy_at[0]), 16'd5);
      chk("b2b_gap2", 16'(rdy_at[2] - rdy_at[1]), 16'd5);
      chk("b2b_first", 16'(rdy_at[0]), 16'd3);
    end
    chk("b2b_mdr", if2.MDR_Out, 16'hCAFE);
    drive2(16'h0000, 0, 0, 1, 0, 0, 16'hCAFE);
    for (int k = 0; k < 10 && if2.BUSY; k++) tick();
    chk("b2b_idle", 16'(if2.BUSY), 16'h0);

    // Reset asserted mid-ACCESS
    drive2(16'h1234, 1, 0, 1, 1, 0, 16'hDEAD);
    tick();
    drive2(16'h0000, 0, 0, 1, 0, 0, 16'hDEAD);
    tick();
    chk("mid_ce_n_pre", 16'(if2.MEM_CE_N), 16'h0);
    Reset = 1'b1;
    #1;
    chk("mid_ce_n", 16'(if2.MEM_CE_N), 16'h1);
    chk("mid_oe_n", 16'(if2.MEM_OE_N), 16'h1);
    chk("mid_we_n", 16'(if2.MEM_WE_N), 16'h1);
    chk("mid_busy", 16'(if2.BUSY), 16'h0);
    tick();
    chk("mid_mar", if2.MAR_Out, 16'h0000);
    chk("mid_mdr", if2.MDR_Out, 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;
    tick();

`ifdef MEM_MMIO_EN
    // MMIO read of FFFF returns SW, strobes stay high
    if2.SW = 10'h2A5;
    drive2(16'hFFFF, 1, 0, 1, 1, 0, 16'h9999);
    tick();
    drive2(16'h0000, 0, 0, 1, 0, 0, 16'h9999);
    chk("io_rd_busy", 16'(if2.BUSY), 16'h1);
    chk("io_rd_ce_n", 16'(if2.MEM_CE_N), 16'h1);
    chk("io_rd_oe_n", 16'(if2.MEM_OE_N), 16'h1);
    for (int k = 0; k < 10 && !if2.MEM_READY; k++) tick();
    chk("io_rd_ready", 16'(if2.MEM_READY), 16'h1);
    chk("io_rd_mdr", if2.MDR_Out, 16'h02A5);
    tick();
    // MMIO write of 00F0 updates IO_OUT
    drive2(16'h00F0, 0, 1, 0, 0, 0, 16'h0000);
    tick();
    drive2(16'h0000, 0, 0, 0, 1, 1, 16'h0000);
    tick();
    drive2(16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    chk("io_wr_we_n", 16'(if2.MEM_WE_N), 16'h1);
    chk("io_wr_ce_n", 16'(if2.MEM_CE_N), 16'h1);
    for (int k = 0; k < 10 && !if2.MEM_READY; k++) tick();
    chk("io_wr_ready", 16'(if2.MEM_READY), 16'h1);
    chk("io_wr_out", if2.IO_OUT, 16'h00F0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
